// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo_delay feedback echo.
//   state_t     : frame sequencer states
//   GAIN_FRAC_W : default fractional bits of the unsigned Q0.N gains
//   saturate()  : clamps a signed value to the range of a dw-bit signed word
package echo_pkg;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      READ,
      CALC,
      DONE
   } state_t;

   localparam int unsigned GAIN_FRAC_W = 8;
   localparam int unsigned SAT_W       = 64;

   // Clamp v to [-2^(dw-1), 2^(dw-1)-1]; caller narrows the result to dw bits.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned             dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous RAM holding the per-channel delay lines.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data, 1-cycle latency; returns the old word when
//           the same address is written in the same cycle (read-before-write)
module echo_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 2048,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/echo_delay.sv
// Multi-channel feedback echo over a block-RAM circular buffer.
// Optional feature macro: ECHO_SATURATE_EN (clamp sums instead of wrapping).
//   clk, rst  : clock, synchronous active-high reset
//   samp_clk  : one-cycle frame strobe, accepted only when idle
//   in_samp   : input frame, channel c at [c*DATA_W +: DATA_W]
//   delay_len : delay in frames (clamped to 1..MAX_DELAY), sampled on strobe
//   fb_gain   : feedback gain Q0.GAIN_W, sampled on strobe
//   mix_gain  : wet gain Q0.GAIN_W, sampled on strobe
//   out_samp  : output frame, held between out_valid pulses
//   out_valid : one-cycle pulse when out_samp updates
//   busy      : high while clearing the buffer or processing a frame
//   overrun   : one-cycle pulse after a dropped strobe
module echo_delay
   import echo_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned MAX_DELAY = 1024,
   parameter int unsigned GAIN_W    = GAIN_FRAC_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         samp_clk,
   input  logic [CHANNELS*DATA_W-1:0]   in_samp,
   input  logic [$clog2(MAX_DELAY):0]   delay_len,
   input  logic [GAIN_W-1:0]            fb_gain,
   input  logic [GAIN_W-1:0]            mix_gain,
   output logic [CHANNELS*DATA_W-1:0]   out_samp,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         overrun
);

   localparam int unsigned PTR_W  = $clog2(MAX_DELAY);
   localparam int unsigned DL_W   = PTR_W + 1;
   localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned ADDR_W = CH_W + PTR_W;
   localparam int unsigned DEPTH  = CHANNELS * MAX_DELAY;
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
   localparam int unsigned SUM_W  = DATA_W + 1;

   state_t                   state, next_state;
   logic [CNT_W-1:0]         clr_cnt;
   logic [PTR_W-1:0]         wp;
   logic [DL_W-1:0]          d_lat;
   logic [GAIN_W-1:0]        fb_lat, mix_lat;
   logic [CH_W-1:0]          ch;
   logic signed [DATA_W-1:0] x_lat   [CHANNELS];
   logic signed [DATA_W-1:0] y_stage [CHANNELS];

   logic                     ram_we_c;
   logic [ADDR_W-1:0]        ram_addr_c;
   logic [DATA_W-1:0]        ram_wdata_c;
   logic [DATA_W-1:0]        ram_rdata;

   logic [DL_W-1:0]          d_eff_c;
   logic [PTR_W-1:0]         rd_ptr_c;
   logic                     clr_done_c, last_ch_c;
   logic signed [DATA_W-1:0] x_c, d_c, y_c, w_c;
   logic signed [PROD_W-1:0] prod_mix_c, prod_fb_c;
   logic signed [SUM_W-1:0]  sum_mix_c, sum_fb_c;

   echo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (ram_wdata_c),
      .rdata (ram_rdata)
   );

   // Effective delay: 0 behaves as 1, anything beyond the line depth as the depth.
   always_comb begin
      d_eff_c = delay_len;
      if (delay_len == '0) begin
         d_eff_c = DL_W'(1);
      end else if (delay_len > DL_W'(MAX_DELAY)) begin
         d_eff_c = DL_W'(MAX_DELAY);
      end
   end

   // D = MAX_DELAY wraps to the write pointer itself; the read precedes the write.
   assign rd_ptr_c   = PTR_W'({1'b0, wp} - d_lat);
   assign clr_done_c = (clr_cnt == CNT_W'(DEPTH));
   assign last_ch_c  = (ch == CH_W'(CHANNELS - 1));

   // Echo arithmetic: signed sample times unsigned gain, full width, then scaled down.
   always_comb begin
      x_c        = x_lat[ch];
      d_c        = $signed(ram_rdata);
      prod_mix_c = PROD_W'(d_c) * PROD_W'($signed({1'b0, mix_lat}));
      prod_fb_c  = PROD_W'(d_c) * PROD_W'($signed({1'b0, fb_lat}));
      sum_mix_c  = SUM_W'(x_c) + SUM_W'(prod_mix_c >>> GAIN_W);
      sum_fb_c   = SUM_W'(x_c) + SUM_W'(prod_fb_c >>> GAIN_W);
`ifdef ECHO_SATURATE_EN
      y_c        = DATA_W'(saturate(SAT_W'(sum_mix_c), DATA_W));
      w_c        = DATA_W'(saturate(SAT_W'(sum_fb_c), DATA_W));
`else
      y_c        = DATA_W'(sum_mix_c);
      w_c        = DATA_W'(sum_fb_c);
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // Next state and RAM port control.
   always_comb begin
      next_state  = state;
      ram_we_c    = 1'b0;
      ram_addr_c  = clr_cnt[ADDR_W-1:0];
      ram_wdata_c = '0;
      case (state)
         CLEAR: begin
            if (clr_done_c) begin
               next_state = IDLE;
            end else begin
               ram_we_c = 1'b1;
            end
         end
         IDLE: begin
            if (samp_clk) begin
               next_state = READ;
            end
         end
         READ: begin
            ram_addr_c = {ch, rd_ptr_c};
            next_state = CALC;
         end
         CALC: begin
            ram_addr_c  = {ch, wp};
            ram_we_c    = 1'b1;
            ram_wdata_c = w_c;
            next_state  = last_ch_c ? DONE : READ;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = CLEAR;
         end
      endcase
   end

   // Frame registers, pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt   <= '0;
         wp        <= '0;
         d_lat     <= DL_W'(1);
         fb_lat    <= '0;
         mix_lat   <= '0;
         ch        <= '0;
         out_samp  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b1;
         overrun   <= 1'b0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            x_lat[i]   <= '0;
            y_stage[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         busy      <= (next_state != IDLE);
         overrun   <= samp_clk && (state != IDLE);
         case (state)
            CLEAR: begin
               if (!clr_done_c) begin
                  clr_cnt <= clr_cnt + CNT_W'(1);
               end
            end
            IDLE: begin
               if (samp_clk) begin
                  d_lat   <= d_eff_c;
                  fb_lat  <= fb_gain;
                  mix_lat <= mix_gain;
                  ch      <= '0;
                  for (int i = 0; i < int'(CHANNELS); i++) begin
                     x_lat[i] <= in_samp[i*DATA_W +: DATA_W];
                  end
               end
            end
            CALC: begin
               y_stage[ch] <= y_c;
               if (!last_ch_c) begin
                  ch <= ch + CH_W'(1);
               end
            end
            DONE: begin
               out_valid <= 1'b1;
               wp        <= wp + PTR_W'(1);
               for (int i = 0; i < int'(CHANNELS); i++) begin
                  out_samp[i*DATA_W +: DATA_W] <= y_stage[i];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_echo_delay.sv
// Self-checking bench for echo_delay: random and directed frames checked
// against a frame-history model of the echo rules.
module tb_echo_delay;

   localparam int DW    = 16;
   localparam int CH    = 2;
   localparam int MD    = 64;
   localparam int GW    = 8;
   localparam int DLW   = $clog2(MD) + 1;
   localparam int NCLR  = CH * MD;
   localparam int LAT   = 2 * CH + 1;
   localparam int HMAX  = 4096;

   logic                clk = 1'b0;
   logic                rst;
   logic                samp_clk;
   logic [CH*DW-1:0]    in_samp;
   logic [DLW-1:0]      delay_len;
   logic [GW-1:0]       fb_gain;
   logic [GW-1:0]       mix_gain;
   logic [CH*DW-1:0]    out_samp;
   logic                out_valid;
   logic                busy;
   logic                overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: every word written per channel, indexed by frame number since reset.
   int          hist [CH][HMAX];
   int          frame_n;
   int          x_cur [CH];
   int          exp_y [CH];
   logic [DW-1:0] last_out [CH];

   echo_delay #(
      .DATA_W    (DW),
      .CHANNELS  (CH),
      .MAX_DELAY (MD),
      .GAIN_W    (GW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .samp_clk  (samp_clk),
      .in_samp   (in_samp),
      .delay_len (delay_len),
      .fb_gain   (fb_gain),
      .mix_gain  (mix_gain),
      .out_samp  (out_samp),
      .out_valid (out_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   function automatic int narrow(input int s);
`ifdef ECHO_SATURATE_EN
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return s;
`else
      logic signed [15:0] t;
      t = s[15:0];
      return int'(t);
`endif
   endfunction

   // One frame of the echo: output reads the word written D frames ago (0 if none).
   task automatic model_frame(input int dl, input int fb, input int mix);
      int d_eff;
      int d;
      d_eff = (dl < 1) ? 1 : ((dl > MD) ? MD : dl);
      for (int c = 0; c < CH; c++) begin
         d = (frame_n >= d_eff) ? hist[c][frame_n - d_eff] : 0;
         exp_y[c] = narrow(x_cur[c] + ((d * mix) >>> GW));
         if (frame_n < HMAX) hist[c][frame_n] = narrow(x_cur[c] + ((d * fb) >>> GW));
      end
      frame_n++;
   endtask

   task automatic drive_inputs(input int dl, input int fb, input int mix);
      for (int c = 0; c < CH; c++) in_samp[c*DW +: DW] = DW'(x_cur[c]);
      delay_len = DLW'(dl);
      fb_gain   = GW'(fb);
      mix_gain  = GW'(mix);
   endtask

   task automatic do_frame(input int dl, input int fb, input int mix);
      int lat;
      bit got;
      logic [DW-1:0] v;
      drive_inputs(dl, fb, mix);
      samp_clk = 1'b1;
      @(posedge clk); #1;
      samp_clk = 1'b0;
      model_frame(dl, fb, mix);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 4 * LAT) begin
         @(posedge clk); #1;
         lat++;
         got = out_valid;
      end
      n_checks++;
      if (!got || lat != LAT || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_latency frame=%0d: got lat=%0d valid=%0b busy=%0b, need lat=%0d valid=1 busy=0",
                  frame_n - 1, lat, got, busy, LAT);
      end
      for (int c = 0; c < CH; c++) begin
         v = out_samp[c*DW +: DW];
         last_out[c] = v;
         n_checks++;
         if (v !== DW'(exp_y[c])) begin
            n_fail++;
            $display("FAIL frame_out frame=%0d ch=%0d: got %h, need %h", frame_n - 1, c, v, DW'(exp_y[c]));
         end
      end
   endtask

   task automatic wait_clear(output int cycles, output int ov, output int vv, input int strobe_at);
      cycles = 0;
      ov = 0;
      vv = 0;
      while (busy === 1'b1 && cycles < NCLR + 50) begin
         cycles++;
         samp_clk = (cycles == strobe_at);
         @(posedge clk); #1;
         if (overrun) ov++;
         if (out_valid) vv++;
      end
      samp_clk = 1'b0;
   endtask

   task automatic test_reset;
      int cycles, ov, vv;
      rst = 1'b1;
      samp_clk = 1'b0;
      in_samp = '0;
      delay_len = '0;
      fb_gain = '0;
      mix_gain = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_samp !== '0) begin n_fail++; $display("FAIL reset_out_samp: got %h, need 0", out_samp); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, need 0", out_valid); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, need 0", overrun); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, need 1", busy); end
      rst = 1'b0;
      frame_n = 0;
      wait_clear(cycles, ov, vv, 10);
      n_checks++;
      if (cycles != NCLR + 1) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d, need %0d", cycles, NCLR + 1); end
      n_checks++;
      if (ov != 1 || vv != 0) begin
         n_fail++;
         $display("FAIL clear_strobe_dropped: got overrun=%0d valid=%0d, need overrun=1 valid=0", ov, vv);
      end
   endtask

   task automatic test_clear_check;
      int need;
      x_cur[1] = 0;
      for (int f = 0; f < 5; f++) begin
         x_cur[0] = (f == 0 || f == 4) ? 32'h4000 : 0;
         do_frame(4, 0, 128);
         need = (f == 0) ? 32'h4000 : ((f == 4) ? 32'h6000 : 0);
         n_checks++;
         if (last_out[0] !== DW'(need) || last_out[1] !== '0) begin
            n_fail++;
            $display("FAIL clear_check f=%0d: got %h/%h, need %h/0000", f, last_out[0], last_out[1], DW'(need));
         end
      end
   endtask

   task automatic test_feedback_decay;
      x_cur[1] = 0;
      for (int f = 0; f < 6; f++) begin
         x_cur[0] = (f == 0) ? 32'h2000 : 0;
         do_frame(2, 128, 255);
         if (f == 2 || f == 4) begin
            n_checks++;
            if (last_out[0] !== ((f == 2) ? 16'h1FE0 : 16'h0FF0)) begin
               n_fail++;
               $display("FAIL decay f=%0d: got %h, need %h", f, last_out[0], (f == 2) ? 16'h1FE0 : 16'h0FF0);
            end
         end
      end
   endtask

   task automatic test_isolation;
      x_cur[1] = 0;
      for (int f = 0; f < 64; f++) begin
         x_cur[0] = (f == 0) ? 32'h1000 : 0;
         do_frame(5, 100, 200);
         n_checks++;
         if (last_out[1] !== '0) begin
            n_fail++;
            $display("FAIL isolation f=%0d: got ch1 %h, need 0000", f, last_out[1]);
         end
      end
   endtask

   task automatic test_saturation;
      logic [DW-1:0] need;
`ifdef ECHO_SATURATE_EN
      need = 16'h7FFF;
`else
      need = 16'hFF7E;
`endif
      x_cur[0] = 32'h7FFF;
      x_cur[1] = 32'h7FFF;
      do_frame(1, 0, 0);
      do_frame(1, 0, 255);
      for (int c = 0; c < CH; c++) begin
         n_checks++;
         if (last_out[c] !== need) begin
            n_fail++;
            $display("FAIL saturation ch=%0d: got %h, need %h", c, last_out[c], need);
         end
      end
   endtask

   task automatic test_overrun;
      int ov, vv, v_at, ov_at;
      logic [DW-1:0] v;
      for (int c = 0; c < CH; c++) x_cur[c] = int'($urandom_range(65535)) - 32768;
      drive_inputs(7, 90, 170);
      samp_clk = 1'b1;
      @(posedge clk); #1;
      samp_clk = 1'b0;
      model_frame(7, 90, 170);
      ov = 0; vv = 0; v_at = 0; ov_at = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         if (overrun) begin ov++; ov_at = k; end
         if (out_valid) begin vv++; v_at = k; end
         if (k == 1) begin
            samp_clk = 1'b1;
            in_samp = {$urandom, $urandom};
            delay_len = DLW'($urandom_range(127));
            fb_gain = GW'($urandom);
            mix_gain = GW'($urandom);
         end else begin
            samp_clk = 1'b0;
         end
      end
      n_checks++;
      if (ov != 1 || ov_at != 2) begin n_fail++; $display("FAIL overrun_pulse: got count=%0d at=%0d, need 1 at 2", ov, ov_at); end
      n_checks++;
      if (vv != 1 || v_at != LAT) begin n_fail++; $display("FAIL overrun_valid: got count=%0d at=%0d, need 1 at %0d", vv, v_at, LAT); end
      for (int c = 0; c < CH; c++) begin
         v = out_samp[c*DW +: DW];
         n_checks++;
         if (v !== DW'(exp_y[c])) begin n_fail++; $display("FAIL overrun_out ch=%0d: got %h, need %h", c, v, DW'(exp_y[c])); end
      end
   endtask

   task automatic test_boundaries;
      x_cur[1] = 0;
      x_cur[0] = 32'h0800;
      do_frame(0, 0, 255);
      x_cur[0] = 0;
      do_frame(0, 0, 255);
      n_checks++;
      if (last_out[0] !== 16'h07F8) begin n_fail++; $display("FAIL delay_zero: got %h, need 07f8", last_out[0]); end
      for (int f = 0; f <= MD; f++) begin
         x_cur[0] = (f == 0) ? 32'h1000 : 0;
         x_cur[1] = (f == 0) ? -32'sh0100 : 0;
         do_frame(MD, 0, 255);
      end
      n_checks++;
      if (last_out[0] !== 16'h0FF0 || last_out[1] !== 16'hFF01) begin
         n_fail++;
         $display("FAIL delay_max: got %h/%h, need 0ff0/ff01", last_out[0], last_out[1]);
      end
   endtask

   task automatic test_random;
      for (int f = 0; f < 150; f++) begin
         for (int c = 0; c < CH; c++) x_cur[c] = int'($urandom_range(65535)) - 32768;
         do_frame(int'($urandom_range(2 * MD - 1)), int'($urandom_range(255)), int'($urandom_range(255)));
      end
   endtask

   task automatic test_reset_mid_calc;
      int cycles, ov, vv;
      for (int c = 0; c < CH; c++) x_cur[c] = int'($urandom_range(65535)) - 32768;
      drive_inputs(3, 200, 200);
      samp_clk = 1'b1;
      @(posedge clk); #1;
      samp_clk = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_calc: got busy=%b valid=%b, need busy=1 valid=0", busy, out_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      frame_n = 0;
      wait_clear(cycles, ov, vv, 0);
      n_checks++;
      if (cycles != NCLR + 1 || vv != 0) begin
         n_fail++;
         $display("FAIL rst_reclear: got cycles=%0d valid=%0d, need cycles=%0d valid=0", cycles, vv, NCLR + 1);
      end
      x_cur[0] = 0;
      x_cur[1] = 0;
      for (int f = 0; f < MD; f++) begin
         do_frame(MD, int'($urandom_range(255)), int'($urandom_range(1, 255)));
         n_checks++;
         if (last_out[0] !== '0 || last_out[1] !== '0) begin
            n_fail++;
            $display("FAIL reclear_zero f=%0d: got %h/%h, need 0000/0000", f, last_out[0], last_out[1]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_clear_check;
      test_feedback_decay;
      test_isolation;
      test_saturation;
      test_overrun;
      test_boundaries;
      test_random;
      test_reset_mid_calc;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/echo_delay.md
# echo_delay

Parametrised multi-channel feedback echo for the audio effects chain, sitting between the sample source and the output mixer on the system clock, paced by the `samp_clk` strobe. It replaces the shift-register delay line with a circular buffer in block RAM. It adds:
- run-time delay length, feedback gain and wet-mix gain;
- signed arithmetic;
- N time-multiplexed channels.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed two's complement.
- `CHANNELS`, 2: number of channels packed in the sample buses.
- `MAX_DELAY`, 1024: delay-line depth per channel, in frames; must be a power of two ≥ 2.
- `GAIN_W`, 8: gain width, unsigned Q0.GAIN_W (full scale = 2^GAIN_W, never reached).

Ports:
- `clk`, input, 1: system clock. One clock; every register updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `samp_clk`, input, 1: one-cycle frame strobe; starts processing of `in_samp`.
- `in_samp`, input, CHANNELS*DATA_W: channel c is in bits [c*DATA_W +: DATA_W].
- `delay_len`, input, clog2(MAX_DELAY)+1: delay in frames; sampled on an accepted strobe.
- `fb_gain`, input, GAIN_W: feedback gain; sampled on an accepted strobe.
- `mix_gain`, input, GAIN_W: wet gain; sampled on an accepted strobe.
- `out_samp`, output, CHANNELS*DATA_W: processed frame, same packing as `in_samp`; held between updates.
- `out_valid`, output, 1: one-cycle pulse when `out_samp` updates.
- `busy`, output, 1: high while clearing or processing.
- `overrun`, output, 1: one-cycle pulse when a `samp_clk` strobe is dropped.

## Operation
- States: CLEAR, IDLE, READ, CALC, DONE.
- Reset drives the block to CLEAR with outputs:
  - `out_samp` = 0, `out_valid` = 0, `overrun` = 0, `busy` = 1;
  - write pointer `wp` = 0, clear address = 0.
- CLEAR:
  - writes 0 to one RAM word per cycle, CHANNELS*MAX_DELAY cycles total;
  - then goes to IDLE, where `busy` = 0.
- IDLE, `samp_clk` = 1:
  - latches `in_samp`, the gains and the effective delay D, where D = `delay_len` clamped to 1..MAX_DELAY (0 → 1, >MAX_DELAY → MAX_DELAY);
  - sets channel index c = 0 and goes to READ.
- READ:
  - reads RAM address {c, (wp − D) mod MAX_DELAY}.
- CALC, using x = input sample and d = RAM read data:
  - y = x + ((d * mix_gain) >>> GAIN_W), which becomes `out_samp` channel c;
  - w = x + ((d * fb_gain) >>> GAIN_W), which is written to RAM address {c, wp};
  - if c < CHANNELS−1: c increments and the state returns to READ; otherwise go to DONE.
- DONE:
  - pulses `out_valid`;
  - `wp` ← (wp + 1) mod MAX_DELAY;
  - goes to IDLE.
- Products are signed DATA_W × unsigned GAIN_W, at full width before the shift.
- Sums are DATA_W+1 bits, then narrowed to DATA_W (see Configuration).
- D = MAX_DELAY gives read address = write address. This is legal: READ precedes the write in CALC, so the old value is returned.
- `samp_clk` while `busy` = 1, including during CLEAR:
  - the strobe is ignored and `overrun` pulses the next cycle;
  - frame state is unchanged.
- `rst` asserted in any state aborts the frame. CLEAR restarts from address 0 and no partial `out_valid` is produced.
- Changing `delay_len` or the gains between frames takes effect on the next accepted strobe, with no glitch in the current frame.

## Timing
- RAM is single-port, synchronous read, 1-cycle latency; read data is used in CALC.
- The strobe is accepted at edge T. Channel c occupies READ at T+1+2c and CALC at T+2+2c.
- DONE is at T+1+2*CHANNELS; `out_valid` is high in the cycle after that edge. Latency is 2*CHANNELS+1 cycles.
- `busy` deasserts in that same cycle. A new strobe is accepted from that cycle on.
- Minimum strobe spacing is 2*CHANNELS+2 cycles.
- After reset is released, `busy` stays high for CHANNELS*MAX_DELAY+1 cycles.

## Configuration
- `ECHO_SATURATE_EN` defined:
  - each DATA_W+1-bit sum clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1] for both `out_samp` and the RAM write.
- Not defined:
  - sums truncate to the low DATA_W bits (two's-complement wrap);
  - no clamp logic is synthesised.

## Structure
- Package `echo_pkg` holds:
  - the state encoding (CLEAR, IDLE, READ, CALC, DONE);
  - the gain fractional-bit constant;
  - the saturate helper function.
- Sub-module `echo_ram`: single-port synchronous RAM, DATA_W × (CHANNELS*MAX_DELAY), with read-before-write on the same cycle; it is inferred as block RAM.
- The top level owns the FSM, pointers, arithmetic and the output register.

## Test plan
- Clear check: release reset, then strobe impulse 0x4000 on channel 0 with D=4, mix=128, fb=0. Frames 1–3 → 0x0000; frame 0 → 0x4000; frame 4 → 0x6000 on ch0 only.
- Feedback decay: D=2, fb=128, mix=255, single impulse 0x2000 then zeros. Echoes appear every 2 frames with amplitude halving each time, e.g. 0x1FE0, 0x0FF0.
- Channel isolation: CHANNELS=2, ch0 impulse 0x1000, ch1 constant 0. Ch1 stays 0 for 64 frames; ch0 echoes at D.
- Saturation: x=0x7FFF, d=0x7FFF, mix=255.
  - With `ECHO_SATURATE_EN`: out=0x7FFF.
  - Without: out=0xFF7E (wrapped).
- Overrun: strobe, then a second strobe 2 cycles later. Required: `overrun` pulses once, exactly one `out_valid`, second frame dropped.
- Boundaries and reset:
  - D=0 behaves as D=1; D=MAX_DELAY echoes after MAX_DELAY frames.
  - `rst` mid-CALC → `busy` high, `out_valid` absent, and the buffer re-reads all zero afterwards.
